bcd_countdown_timer: RTL and testbench

Two-digit BCD countdown engine for the two-mode timer. It loads a BCD preset (high and low digits) and counts it down to 00 on tick enables. In parallel it produces the matching elapsed (up-count) value, so both display modes are driven natively from one state machine. It sits between the 1 Hz tick generator and the display/mode mux, and reports run and done status to the control logic.

---
 rtl/bcd_countdown_timer.sv | 140 ++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown engine: loads a preset, counts Remain down to 00
// on prescaled tick enables and produces the matching elapsed up-count.
module bcd_countdown_timer #(
    parameter int unsigned TICKS_PER_STEP = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       TickEn,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Clear,
    input  logic [3:0] PresetH,
    input  logic [3:0] PresetL,
    output logic [7:0] RemainOut,
    output logic [7:0] ElapsedOut,
    output logic       Running,
    output logic       Done,
    output logic       DonePulse
);

    localparam int unsigned PW = 8;
    localparam int unsigned DW = 8;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   remain_q, remain_d;
    logic [DW-1:0]   elapsed_q, elapsed_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            pulse_q, pulse_d;
    logic [DW-1:0]   preset_c;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign preset_c = {clamp_digit(PresetH), clamp_digit(PresetL)};

    // Next-state and registered-output intent; Clear outranks Start/Pause/TickEn.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        elapsed_d = elapsed_q;
        presc_d   = presc_q;
        pulse_d   = 1'b0;

        if (Clear) begin
            state_d   = S_IDLE;
            remain_d  = 8'h00;
            elapsed_d = 8'h00;
            presc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        elapsed_d = 8'h00;
                        presc_d   = '0;
                        if (preset_c == 8'h00) begin
                            state_d  = S_DONE;
                            remain_d = 8'h00;
                            pulse_d  = 1'b1;
                        end else begin
                            state_d  = S_RUN;
                            remain_d = preset_c;
                        end
                    end
                end
                S_RUN: begin
                    if (Pause) begin
                        state_d = S_PAUSED;
                    end else if (TickEn) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d   = '0;
                            remain_d  = bcd_dec(remain_q);
                            elapsed_d = bcd_inc(elapsed_q);
                            if (remain_q == 8'h01) begin
                                state_d = S_DONE;
                                pulse_d = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                S_PAUSED: begin
                    if (Start && !Pause) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            remain_q  <= 8'h00;
            elapsed_q <= 8'h00;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            elapsed_q <= elapsed_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            pulse_q   <= pulse_d;
        end
    end

    assign RemainOut  = remain_q;
    assign ElapsedOut = elapsed_q;
    assign Running    = running_q;
    assign Done       = done_q;
    assign DonePulse  = pulse_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one instance at 1 tick/step,
// one at 10 ticks/step, both driven by the same stimulus.
module tb_bcd_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       TickEn = 1'b0;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] PresetH = 4'h0;
    logic [3:0] PresetL = 4'h0;

    logic [7:0] r1, e1, r10, e10;
    logic       run1, done1, dp1, run10, done10, dp10;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int val;

    always #5 clock = ~clock;

    bcd_countdown_timer #(.TICKS_PER_STEP(1)) dut1 (
        .clock(clock), .reset(reset), .TickEn(TickEn), .Start(Start),
        .Pause(Pause), .Clear(Clear), .PresetH(PresetH), .PresetL(PresetL),
        .RemainOut(r1), .ElapsedOut(e1), .Running(run1), .Done(done1),
        .DonePulse(dp1)
    );

    bcd_countdown_timer #(.TICKS_PER_STEP(10)) dut10 (
        .clock(clock), .reset(reset), .TickEn(TickEn), .Start(Start),
        .Pause(Pause), .Clear(Clear), .PresetH(PresetH), .PresetL(PresetL),
        .RemainOut(r10), .ElapsedOut(e10), .Running(run10), .Done(done10),
        .DonePulse(dp10)
    );

    function automatic logic [7:0] to_bcd(input int d);
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        TickEn = 1'b1;
        step();
        TickEn = 1'b0;
    endtask

    task automatic start_with(input logic [3:0] h, input logic [3:0] l);
        PresetH = h;
        PresetL = l;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        step();
        reset = 1'b0;
        chk("rst_remain", r1, 8'h00);
        chk("rst_elapsed", e1, 8'h00);
        chk("rst_running", {7'd0, run1}, 8'h00);
        chk("rst_done", {7'd0, done1}, 8'h00);
        chk("rst_pulse", {7'd0, dp1}, 8'h00);

        // Full countdown from 12
        start_with(4'h1, 4'h2);
        chk("t1_load_remain", r1, 8'h12);
        chk("t1_load_elapsed", e1, 8'h00);
        chk("t1_load_running", {7'd0, run1}, 8'h01);
        for (int i = 1; i <= 12; i++) begin
            tick();
            val = 12 - i;
            chk("t1_remain", r1, to_bcd(val));
            chk("t1_elapsed", e1, to_bcd(i));
            if (dp1) pulses++;
        end
        chk("t1_done_on_zero", {7'd0, done1}, 8'h01);
        chk("t1_pulse_at_zero", {7'd0, dp1}, 8'h01);
        chk("t1_running_off", {7'd0, run1}, 8'h00);
        tick();
        if (dp1) pulses++;
        chk("t1_pulse_count", 8'(pulses), 8'd1);
        chk("t1_done_hold", {7'd0, done1}, 8'h01);
        chk("t1_done_remain", r1, 8'h00);
        chk("t1_done_elapsed", e1, 8'h12);

        // Borrow/carry and preset clamping
        start_with(4'h2, 4'h0);
        tick();
        chk("t2_borrow_remain", r1, 8'h19);
        chk("t2_carry_elapsed", e1, 8'h01);
        do_clear();
        start_with(4'h9, 4'hF);
        chk("t2_clamp_remain", r1, 8'h99);
        tick();
        chk("t2_clamp_step", r1, 8'h98);
        chk("t2_clamp_elapsed", e1, 8'h01);

        // Zero preset goes straight to DONE
        do_clear();
        start_with(4'h0, 4'h0);
        chk("t3_done", {7'd0, done1}, 8'h01);
        chk("t3_pulse", {7'd0, dp1}, 8'h01);
        chk("t3_running", {7'd0, run1}, 8'h00);
        chk("t3_remain", r1, 8'h00);
        step();
        chk("t3_pulse_once", {7'd0, dp1}, 8'h00);
        chk("t3_done_hold", {7'd0, done1}, 8'h01);

        // Pause at 15 together with TickEn, then resume
        start_with(4'h2, 4'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_pre_pause", r1, 8'h15);
        Pause = 1'b1;
        TickEn = 1'b1;
        step();
        Pause = 1'b0;
        TickEn = 1'b0;
        chk("t4_pause_remain", r1, 8'h15);
        chk("t4_pause_running", {7'd0, run1}, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_frozen", r1, 8'h15);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("t4_resume_running", {7'd0, run1}, 8'h01);
        chk("t4_resume_remain", r1, 8'h15);
        tick();
        chk("t4_next_step", r1, 8'h14);
        chk("t4_next_elapsed", e1, 8'h06);

        // Clear at 07 and reset mid-run
        for (int i = 0; i < 7; i++) tick();
        chk("t6_at_07", r1, 8'h07);
        do_clear();
        chk("t6_clear_remain", r1, 8'h00);
        chk("t6_clear_elapsed", e1, 8'h00);
        chk("t6_clear_running", {7'd0, run1}, 8'h00);
        start_with(4'h2, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_mid_run", r1, 8'h17);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_remain", r1, 8'h00);
        chk("t6_rst_elapsed", e1, 8'h00);
        chk("t6_rst_running", {7'd0, run1}, 8'h00);
        chk("t6_rst_done", {7'd0, done1}, 8'h00);

        // Prescaler of 10 with pause mid-prescale
        start_with(4'h0, 4'h3);
        chk("t5_load", r10, 8'h03);
        for (int i = 0; i < 9; i++) tick();
        chk("t5_no_step_9", r10, 8'h03);
        tick();
        chk("t5_step_10", r10, 8'h02);
        chk("t5_elapsed_10", e10, 8'h01);
        for (int i = 0; i < 4; i++) tick();
        Pause = 1'b1;
        TickEn = 1'b1;
        step();
        Pause = 1'b0;
        TickEn = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_paused", r10, 8'h02);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("t5_resumed", {7'd0, run10}, 8'h01);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_phase_hold", r10, 8'h02);
        tick();
        chk("t5_phase_step", r10, 8'h01);
        chk("t5_phase_elapsed", e10, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
